// File: rtl/pp_tx_msg_writer.sv
// pp_tx_msg_writer: loads one message from the post-processing word stream
// into BRAMMsgTX, hands it to the network controller and waits for release.
//   clk_PP, reset           : clock, asynchronous active-high reset
//   start, msg_len          : send request and its length in words
//   src_data/valid/ready    : payload word stream
//   busy_Net2PP_TX          : buffer held by the network controller
//   busy_PP2Net_TX          : buffer held by this block
//   dataTX/addrTX/weTX_msg  : BRAMMsgTX port A write side
//   sizeTX_msg, msg_stored  : published word count and completion pulse
//   done, err               : release pulse, bad-length/timeout pulse
// NET_TIMEOUT must be at least 2.
module pp_tx_msg_writer #(
   parameter int unsigned MAX_WORDS   = 1024,
   parameter int unsigned NET_TIMEOUT = 4096
) (
   input  logic        clk_PP,
   input  logic        reset,
   input  logic        start,
   input  logic [10:0] msg_len,
   input  logic [31:0] src_data,
   input  logic        src_valid,
   output logic        src_ready,
   input  logic        busy_Net2PP_TX,
   output logic        busy_PP2Net_TX,
   output logic        msg_stored,
   output logic [31:0] dataTX_msg,
   output logic [10:0] addrTX_msg,
   output logic        weTX_msg,
   output logic [10:0] sizeTX_msg,
   output logic        done,
   output logic        err
);

   localparam int unsigned LEN_W  = 11;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TMO_W  = $clog2(NET_TIMEOUT + 1);

   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_WORDS);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(NET_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_BUS  = 3'd1,
      ST_WRITE     = 3'd2,
      ST_STORED    = 3'd3,
      ST_WAIT_TAKE = 3'd4,
      ST_WAIT_REL  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   wcnt_q, wcnt_d;
   logic [TMO_W-1:0]   tcnt_q, tcnt_d;

   logic               busy_d, stored_d, we_d, done_d, err_d;
   logic [DATA_W-1:0]  data_d;
   logic [LEN_W-1:0]   addr_d, size_d;

   // Payload is accepted only while writing; decoded straight from the state register.
   assign src_ready = (state_q == ST_WRITE);

   // Next-state and next-output decode.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      wcnt_d   = wcnt_q;
      tcnt_d   = tcnt_q;
      busy_d   = busy_PP2Net_TX;
      stored_d = 1'b0;
      we_d     = 1'b0;
      data_d   = dataTX_msg;
      addr_d   = addrTX_msg;
      size_d   = sizeTX_msg;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d = msg_len;
               if ((msg_len == '0) || (msg_len > MAX_LEN)) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_WAIT_BUS;
               end
            end
         end

         ST_WAIT_BUS: begin
            if (!busy_Net2PP_TX) begin
               busy_d  = 1'b1;
               wcnt_d  = '0;
               state_d = ST_WRITE;
            end
         end

         ST_WRITE: begin
            if (src_valid) begin
               we_d   = 1'b1;
               data_d = src_data;
               addr_d = wcnt_q;
               if (wcnt_q == (len_q - LEN_W'(1))) begin
                  // Completion outputs register with the last write so they
                  // are visible during the STORED cycle.
                  busy_d   = 1'b0;
                  stored_d = 1'b1;
                  size_d   = len_q;
                  state_d  = ST_STORED;
               end else begin
                  wcnt_d = wcnt_q + LEN_W'(1);
               end
            end
         end

         ST_STORED: begin
            // The msg_stored cycle counts as the first timeout cycle, so a
            // timeout err lands NET_TIMEOUT cycles after msg_stored.
            tcnt_d  = TMO_W'(1);
            state_d = ST_WAIT_TAKE;
         end

         ST_WAIT_TAKE: begin
            if (busy_Net2PP_TX) begin
               state_d = ST_WAIT_REL;
            end else if (tcnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tcnt_d = tcnt_q + TMO_W'(1);
            end
         end

         ST_WAIT_REL: begin
            if (!busy_Net2PP_TX) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk_PP or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         len_q          <= '0;
         wcnt_q         <= '0;
         tcnt_q         <= '0;
         busy_PP2Net_TX <= 1'b0;
         msg_stored     <= 1'b0;
         weTX_msg       <= 1'b0;
         dataTX_msg     <= '0;
         addrTX_msg     <= '0;
         sizeTX_msg     <= '0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         wcnt_q         <= wcnt_d;
         tcnt_q         <= tcnt_d;
         busy_PP2Net_TX <= busy_d;
         msg_stored     <= stored_d;
         weTX_msg       <= we_d;
         dataTX_msg     <= data_d;
         addrTX_msg     <= addr_d;
         sizeTX_msg     <= size_d;
         done           <= done_d;
         err            <= err_d;
      end
   end

endmodule
